// File: rtl/spi_rom_pkg.sv
// spi_rom_pkg: shared constants and FSM states for the SPI EEPROM read sequencer
package spi_rom_pkg;
  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic REQ_BOOT = 1'b0;
  localparam logic REQ_CPU = 1'b1;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_CS_SETUP,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CS_HIGH,
    ST_GAP
  } state_t;
endpackage

// File: rtl/spi_rr_arb2.sv
// spi_rr_arb2: two-way round-robin arbiter with last-grant pointer
module spi_rr_arb2 (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic last_q;
  // a lone request wins outright; on a tie the requester not granted last wins
  always_comb gnt_o = req_i == 2'b11 ? (last_q ? 2'b01 : 2'b10) : req_i;
  // remember the latest winner; reset points at requester 1 so requester 0 is favoured
  always_ff @(posedge clk)
    if (!rst_ni) last_q <= 1'b1;
    else if (en_i && |req_i) last_q <= gnt_o[1];
endmodule

// File: rtl/spi_rom_read_ctrl.sv
// spi_rom_read_ctrl: arbitrated READ sequencer for an M95xxx SPI EEPROM (mode 0)
module spi_rom_read_ctrl
  import spi_rom_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int ADDR_BITS = 16,
  parameter int CS_GAP    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req,
  input  logic [ADDR_BITS-1:0] addr0,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [7:0]           len0,
  input  logic [7:0]           len1,
  output logic [1:0]           grant,
  output logic                 rd_valid,
  output logic [7:0]           rd_data,
  output logic                 rd_id,
  output logic                 done,
  output logic                 busy,
  input  logic                 miso,
  output logic                 spi_clk_out,
  output logic                 mosi_out,
  output logic                 spi_en_out
);
  localparam int CW = $clog2((CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP) + 1);
  localparam int BW = $clog2((ADDR_BITS > 8 ? ADDR_BITS : 8) + 1);
  localparam int TW = 8 + ADDR_BITS;
  state_t        state_q;
  logic [CW-1:0] div_q;
  logic [BW-1:0] bit_q;
  logic [7:0]    byte_q, rd_data_q;
  logic [6:0]    rx_q;
  logic [TW-1:0] tx_q;
  logic [1:0]    grant_q, win;
  logic          id_q, sck_q, mosi_q, en_q, rd_valid_q, done_q, busy_q;
  logic          wrap, shifting, rise, fall;
  spi_rr_arb2 u_arb (
    .clk   (clk),
    .rst_ni(reset),
    .en_i  (state_q == ST_IDLE),
    .req_i (req),
    .gnt_o (win)
  );
  assign wrap     = div_q == CW'(CLK_DIV - 1);
  assign shifting = state_q inside {ST_CS_SETUP, ST_CMD, ST_ADDR, ST_DATA};
  assign rise     = shifting && wrap && !sck_q;
  assign fall     = shifting && wrap && sck_q;
  assign grant       = grant_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_id       = id_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign spi_clk_out = sck_q;
  assign mosi_out    = mosi_q;
  assign spi_en_out  = en_q;
  // sequencer: the CS_SETUP wrap is the first SCK rise; phase changes happen on falling edges
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      rd_data_q  <= '0;
      grant_q    <= '0;
      id_q       <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      en_q       <= 1'b1;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      grant_q    <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      div_q      <= wrap ? '0 : div_q + CW'(1);
      if (rise) begin
        sck_q <= 1'b1;
        bit_q <= bit_q + BW'(1);
        rx_q  <= {rx_q[5:0], miso};
      end
      if (fall) begin
        sck_q  <= 1'b0;
        mosi_q <= tx_q[TW-2];
        tx_q   <= {tx_q[TW-2:0], 1'b0};
      end
      case (state_q)
        ST_IDLE:
          if (|req) begin
            state_q <= ST_GRANT;
            grant_q <= win;
            busy_q  <= 1'b1;
            id_q    <= win[REQ_CPU];
            tx_q    <= {CMD_READ, win[REQ_CPU] ? addr1 : addr0};
            byte_q  <= win[REQ_CPU] ? len1 : len0;
          end
        ST_GRANT: begin
          state_q <= ST_CS_SETUP;
          en_q    <= 1'b0;
          mosi_q  <= tx_q[TW-1];
          div_q   <= '0;
          bit_q   <= '0;
        end
        ST_CS_SETUP: if (wrap) state_q <= ST_CMD;
        ST_CMD:
          if (fall && bit_q == BW'(8)) begin
            state_q <= ST_ADDR;
            bit_q   <= '0;
          end
        ST_ADDR:
          if (fall && bit_q == BW'(ADDR_BITS)) begin
            state_q <= ST_DATA;
            bit_q   <= '0;
          end
        ST_DATA:
          if (rise && bit_q == BW'(7)) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= {rx_q, miso};
            bit_q      <= '0;
            byte_q     <= byte_q - 8'd1;
            if (byte_q == 8'd0) state_q <= ST_CS_HIGH;
          end
        ST_CS_HIGH:
          if (wrap) begin
            state_q <= ST_GAP;
            sck_q   <= 1'b0;
            en_q    <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        ST_GAP: begin
          div_q <= div_q + CW'(1);
          if (div_q == CW'(CS_GAP - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_rom_read_ctrl.sv
// tb_spi_rom_read_ctrl: randomized scoreboard bench with an M95xxx EEPROM model
module tb_spi_rom_read_ctrl;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 8;
  typedef struct {logic id; logic [15:0] addr; logic [7:0] len;} txn_t;
  typedef struct {logic id; logic [7:0] data;} byte_t;
  logic clk = 1'b0, reset = 1'b0, miso = 1'b0;
  logic [1:0] req = '0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0] len0 = '0, len1 = '0;
  logic [1:0] grant;
  logic [7:0] rd_data;
  logic rd_valid, rd_id, done, busy, spi_clk_out, mosi_out, spi_en_out;
  int checks = 0, errors = 0;
  logic [7:0] img [0:65535];
  txn_t exp_txn [$];
  byte_t exp_byte [$];
  logic [1:0] exp_grant [$];
  logic model_last = 1'b1;
  int rc = 0, cap_rc = 0;
  logic [23:0] ca = '0, cap_ca = '0;

  spi_rom_read_ctrl #(.CLK_DIV(CLK_DIV), .ADDR_BITS(16), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .grant(grant), .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .done(done), .busy(busy),
    .miso(miso), .spi_clk_out(spi_clk_out), .mosi_out(mosi_out), .spi_en_out(spi_en_out)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic void unexp(string name);
    checks++;
    errors++;
    $display("FAIL %s actual=pulse expected=none", name);
  endfunction

  // EEPROM: shift in command+address on SCK rise, shift data out on SCK fall
  always @(negedge spi_en_out) begin rc = 0; ca = '0; end
  always @(posedge spi_en_out) begin cap_rc = rc; cap_ca = ca; end
  always @(posedge spi_clk_out) if (!spi_en_out) begin
    if (rc < 24) ca = {ca[22:0], mosi_out};
    rc++;
  end
  always @(negedge spi_clk_out) if (!spi_en_out && rc >= 24) begin
    int idx;
    logic [15:0] ba;
    idx = rc - 24;
    ba = ca[15:0] + 16'(idx / 8);
    miso = img[ba][7 - idx % 8];
  end

  // reference model: arbitration rule plus byte stream from the image
  function automatic void push(logic id, logic [15:0] a, logic [7:0] l);
    exp_grant.push_back(id ? 2'b10 : 2'b01);
    exp_txn.push_back('{id, a, l});
    for (int i = 0; i <= int'(l); i++) exp_byte.push_back('{id, img[16'(int'(a) + i)]});
    model_last = id;
  endfunction

  // monitor
  int cyc = 0, last_rv = 0, byte_idx = 0, hi_cnt = 0;
  logic sck_bad = 1'b0, gap_arm = 1'b0, prev_en = 1'b1;
  txn_t t;
  byte_t b;
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin byte_idx = 0; gap_arm = 1'b0; end
    if (grant != 2'b00) begin
      if (exp_grant.size() == 0) unexp("grant");
      else chk("grant", grant, exp_grant.pop_front());
    end
    if (rd_valid) begin
      if (exp_byte.size() == 0) unexp("rd_valid");
      else begin
        b = exp_byte.pop_front();
        chk("rd_data", rd_data, b.data);
        chk("rd_id", rd_id, b.id);
        if (byte_idx > 0) chk("rd_spacing", cyc - last_rv, 16 * CLK_DIV);
        byte_idx++;
        last_rv = cyc;
      end
    end
    if (done) begin
      if (exp_txn.size() == 0) unexp("done");
      else begin
        t = exp_txn.pop_front();
        chk("mosi_cmd_addr", cap_ca, {8'h03, t.addr});
        chk("sck_periods", cap_rc, 8 + 16 + 8 * (int'(t.len) + 1));
        chk("done_id", rd_id, t.id);
        chk("done_cs_high", spi_en_out, 1'b1);
        byte_idx = 0;
        gap_arm = 1'b1;
      end
    end
    if (spi_en_out) begin
      hi_cnt++;
      if (spi_clk_out) sck_bad = 1'b1;
    end else begin
      if (prev_en) begin
        chk("sck_low_while_cs_high", sck_bad, 1'b0);
        if (gap_arm) chk("cs_gap_min", hi_cnt >= CS_GAP + 1, 1'b1);
        gap_arm = 1'b0;
      end
      hi_cnt = 0;
      sck_bad = 1'b0;
    end
    prev_en = spi_en_out;
  end

  task automatic issue(input logic [1:0] m, input logic [15:0] a0, input logic [7:0] l0,
                       input logic [15:0] a1, input logic [7:0] l1);
    logic first;
    int n = 0;
    first = (m == 2'b11) ? !model_last : m[1];
    push(first, first ? a1 : a0, first ? l1 : l0);
    if (m == 2'b11) push(!first, first ? a0 : a1, first ? l0 : l1);
    @(negedge clk);
    addr0 = a0; len0 = l0; addr1 = a1; len1 = l1; req = m;
    while (req != 2'b00 && n < 20000) begin
      @(negedge clk);
      req = req & ~grant;
      n++;
    end
    if (req != 2'b00) begin
      checks++; errors++;
      $display("FAIL grant_timeout actual=%0b expected=00", req);
      req = '0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || exp_txn.size() != 0) && n < 30000);
    if (n >= 30000) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_last = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 65536; i++) img[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", spi_en_out, 1'b1);
    chk("rst_sck", spi_clk_out, 1'b0);
    chk("rst_mosi", mosi_out, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_flags", {rd_valid, done, busy, rd_id}, 4'b0000);
    chk("rst_rd_data", rd_data, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    issue(2'b01, 16'h0000, 8'd3, 16'h0000, 8'd0);
    wait_idle();
    do_reset();
    issue(2'b11, 16'($urandom), 8'($urandom_range(0, 4)), 16'($urandom), 8'($urandom_range(0, 4)));
    wait_idle();
    issue(2'b11, 16'($urandom), 8'($urandom_range(0, 4)), 16'($urandom), 8'($urandom_range(0, 4)));
    wait_idle();
    issue(2'b10, 16'h0000, 8'd0, 16'($urandom), 8'd0);
    wait_idle();
    issue(2'b01, 16'($urandom), 8'd255, 16'h0000, 8'd0);
    wait_idle();
    issue(2'b01, 16'hFFFE, 8'd3, 16'h0000, 8'd0);
    wait_idle();
    issue(2'b01, 16'h1234, 8'd2, 16'h0000, 8'd0);
    @(negedge clk);
    n = 0;
    while (rc < 12 && n < 5000) begin @(negedge clk); n++; end
    chk("reached_addr_phase", rc >= 12 && rc < 24, 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_en", spi_en_out, 1'b1);
    chk("abort_sck", spi_clk_out, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    exp_txn.delete();
    exp_byte.delete();
    exp_grant.delete();
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    issue(2'b01, 16'($urandom), 8'($urandom_range(0, 5)), 16'h0000, 8'd0);
    wait_idle();
    issue(2'b10, 16'h0000, 8'd0, 16'($urandom), 8'd2);
    issue(2'b10, 16'h0000, 8'd0, 16'($urandom), 8'd1);
    wait_idle();
    for (int k = 0; k < 10; k++) begin
      issue(2'($urandom_range(1, 3)), 16'($urandom), 8'($urandom_range(0, 6)),
            16'($urandom), 8'($urandom_range(0, 6)));
      wait_idle();
    end
    chk("left_bytes", exp_byte.size(), 0);
    chk("left_grants", exp_grant.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
